sd_spi_init_seq: RTL and testbench
==================================

SD_SPI_INIT_SEQ -- requirements
Module: sd_spi_init_seq

Interface
REQ-001 Parameter MAX_RETRY, default 16'd1000: max CMD55/ACMD41 pair issues before failure.
REQ-002 Parameter TIMEOUT_CYC, default 20'd400000: max spi_clk_i cycles from spi_start_o to frame completion.
REQ-003 spi_clk_i  in  1  system clock; block is rising-edge.
REQ-004 spi_rst_i  in  1  reset, asynchronous, active-low.
REQ-005 init_req_i  in  1  start card-init sequence; sampled in IDLE/DONE/ERROR only.
REQ-006 spi_done_i  in  1  frame-complete level from SPI engine.
REQ-007 resp_i  in  80  received frame from SPI engine, MSB-first packing.
REQ-008 spi_start_o  out  1  one-cycle frame-start pulse to engine.
REQ-009 cmd_frame_o  out  48  command frame to engine.
REQ-010 clk_div_o  out  2  engine clock divider select.
REQ-011 spi_sendenb_o  out  1  chained-frame enable; constant 0.
REQ-012 busy_o  out  1  sequence in progress.
REQ-013 init_done_o  out  1  sticky success flag.
REQ-014 init_err_o  out  1  sticky failure flag.
REQ-015 err_code_o  out  3  failing step: 1 CMD0, 2 CMD8, 3 CMD55, 4 ACMD41, 5 CMD16, 6 retry exhausted, 7 timeout.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, EVAL, DONE, ERROR; step register selects CMD0, CMD8, CMD55, ACMD41, CMD16.
REQ-017 Frames: CMD0 48'h400000000095; CMD8 48'h48000001AA87; CMD55 48'h770000000001; ACMD41 48'h694000000001; CMD16 48'h500000020001.
REQ-018 IDLE/DONE/ERROR + init_req_i=1 -> ISSUE, step=CMD0, retry=0, clear init_done_o/init_err_o/err_code_o, clk_div_o=2'b00.
REQ-019 ISSUE: cmd_frame_o = step frame, spi_start_o=1 for exactly one cycle, timeout counter cleared, -> WAIT next cycle.
REQ-020 cmd_frame_o held stable from ISSUE until next ISSUE.
REQ-021 WAIT: spi_done_i ignored on first WAIT cycle; thereafter a registered 0->1 transition of spi_done_i -> EVAL, resp_i captured on that cycle.
REQ-022 WAIT: timeout counter increments each cycle; reaching TIMEOUT_CYC -> ERROR, err_code_o=7.
REQ-023 R1 = resp_i[7:0] for CMD0/CMD55/ACMD41/CMD16; for CMD8, R1 = resp_i[39:32] and echo = resp_i[11:0].
REQ-024 EVAL CMD0: R1==8'h01 -> step CMD8; else ERROR code 1.
REQ-025 EVAL CMD8: R1==8'h01 and echo==12'h1AA -> step CMD55; else ERROR code 2.
REQ-026 EVAL CMD55: R1==8'h01 or 8'h00 -> step ACMD41; else ERROR code 3.
REQ-027 EVAL ACMD41: R1==8'h00 -> step CMD16; R1==8'h01 -> retry+1, step CMD55 if retry+1 < MAX_RETRY, else ERROR code 6; other -> ERROR code 4.
REQ-028 EVAL CMD16: R1==8'h00 -> DONE; else ERROR code 5.
REQ-029 EVAL non-terminal outcome -> ISSUE next cycle (EVAL lasts one cycle).
REQ-030 DONE: init_done_o=1, clk_div_o=2'b11; ERROR: init_err_o=1, clk_div_o=2'b00; both held until next init_req_i.
REQ-031 busy_o=1 in ISSUE, WAIT, EVAL; 0 otherwise.
REQ-032 init_req_i while busy_o=1 ignored.
REQ-033 retry counter 16-bit, saturating, never wraps.

Reset
REQ-034 spi_rst_i=0 at any time, including mid-frame: state=IDLE, spi_start_o=0, cmd_frame_o=48'hFFFFFFFFFFFF, clk_div_o=2'b00, spi_sendenb_o=0, busy_o=0, init_done_o=0, init_err_o=0, err_code_o=0, counters 0.
REQ-035 Release of reset issues no spi_start_o until init_req_i=1.

Verification
REQ-036 Happy path: engine model returns 0x01, R7 1AA, 0x01, 0x00, 0x00 -> frames CMD0,CMD8,CMD55,ACMD41,CMD16 in order; init_done_o=1, clk_div_o=2'b11, 5 start pulses.
REQ-037 ACMD41 answers 0x01 three times then 0x00 -> 4 CMD55/ACMD41 pairs, then CMD16, DONE.
REQ-038 MAX_RETRY=4, ACMD41 always 0x01 -> 4 pairs, init_err_o=1, err_code_o=6, no 5th CMD55.
REQ-039 CMD8 echo 12'h0AA -> ERROR, err_code_o=2, clk_div_o=2'b00.
REQ-040 spi_done_i never rises, TIMEOUT_CYC=100 -> ERROR, err_code_o=7 exactly 100 cycles after WAIT entry.
REQ-041 spi_rst_i low during ACMD41 WAIT -> all outputs reset values immediately; new init_req_i restarts at CMD0.

Source files
------------

// File: rtl/sd_spi_init_seq.sv
// sd_spi_init_seq: SD card SPI-mode initialisation sequencer.
// Drives CMD0, CMD8, CMD55/ACMD41 (repeated while the card reports idle) and
// CMD16 through an external SPI frame engine, then flags success or the step
// that failed. All outputs are registered.
module sd_spi_init_seq #(
    parameter logic [15:0] MAX_RETRY   = 16'd1000,
    parameter logic [19:0] TIMEOUT_CYC = 20'd400000
) (
    input  logic        spi_clk_i,
    input  logic        spi_rst_i,
    input  logic        init_req_i,
    input  logic        spi_done_i,
    input  logic [79:0] resp_i,
    output logic        spi_start_o,
    output logic [47:0] cmd_frame_o,
    output logic [1:0]  clk_div_o,
    output logic        spi_sendenb_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        init_err_o,
    output logic [2:0]  err_code_o
);

    localparam logic [47:0] FrameCmd0   = 48'h400000000095;
    localparam logic [47:0] FrameCmd8   = 48'h48000001AA87;
    localparam logic [47:0] FrameCmd55  = 48'h770000000001;
    localparam logic [47:0] FrameAcmd41 = 48'h694000000001;
    localparam logic [47:0] FrameCmd16  = 48'h500000020001;
    localparam logic [47:0] FrameIdle   = 48'hFFFFFFFFFFFF;

    typedef enum logic [2:0] {
        StIdle, StIssue, StWait, StEval, StDone, StError
    } state_e;

    typedef enum logic [2:0] {
        StepCmd0, StepCmd8, StepCmd55, StepAcmd41, StepCmd16
    } step_e;

    state_e      r_state;
    step_e       r_step;
    logic [15:0] r_retry;
    logic [19:0] r_tmo;
    logic        r_first_wait;
    logic        r_done_prev;
    logic [7:0]  r_resp_hi;   // resp_i[39:32]: R1 position inside the R7 reply
    logic [11:0] r_resp_lo;   // resp_i[11:0]: R1 of short replies, echo of R7
    logic        r_start;
    logic [47:0] r_frame;
    logic [1:0]  r_clk_div;
    logic        r_busy;
    logic        r_init_done;
    logic        r_init_err;
    logic [2:0]  r_err_code;

    logic        w_done_rise;
    logic [19:0] w_tmo_inc;
    logic [15:0] w_retry_inc;
    logic [7:0]  w_r1;
    logic [11:0] w_echo;
    step_e       w_next_step;
    logic        w_fail;
    logic        w_finish;
    logic [2:0]  w_code;
    logic [15:0] w_retry_nx;
    logic        w_unused_resp;

    function automatic logic [47:0] frame_of(input step_e s);
        case (s)
            StepCmd0:   return FrameCmd0;
            StepCmd8:   return FrameCmd8;
            StepCmd55:  return FrameCmd55;
            StepAcmd41: return FrameAcmd41;
            StepCmd16:  return FrameCmd16;
            default:    return FrameIdle;
        endcase
    endfunction

    assign w_done_rise   = spi_done_i & ~r_done_prev;
    assign w_tmo_inc     = r_tmo + 20'd1;
    assign w_retry_inc   = (r_retry == 16'hFFFF) ? r_retry : r_retry + 16'd1;
    assign w_r1          = (r_step == StepCmd8) ? r_resp_hi : r_resp_lo[7:0];
    assign w_echo        = r_resp_lo;
    assign w_unused_resp = ^{resp_i[79:40], resp_i[31:12]};

    // Decode the captured response for the current step into the next action.
    always_comb begin
        w_next_step = r_step;
        w_fail      = 1'b0;
        w_finish    = 1'b0;
        w_code      = 3'd0;
        w_retry_nx  = r_retry;
        case (r_step)
            StepCmd0: begin
                if (w_r1 == 8'h01) w_next_step = StepCmd8;
                else begin w_fail = 1'b1; w_code = 3'd1; end
            end
            StepCmd8: begin
                if (w_r1 == 8'h01 && w_echo == 12'h1AA) w_next_step = StepCmd55;
                else begin w_fail = 1'b1; w_code = 3'd2; end
            end
            StepCmd55: begin
                if (w_r1 == 8'h01 || w_r1 == 8'h00) w_next_step = StepAcmd41;
                else begin w_fail = 1'b1; w_code = 3'd3; end
            end
            StepAcmd41: begin
                if (w_r1 == 8'h00) begin
                    w_next_step = StepCmd16;
                end else if (w_r1 == 8'h01) begin
                    // Card still idle: another CMD55/ACMD41 pair, within the budget.
                    w_retry_nx = w_retry_inc;
                    if (w_retry_inc < MAX_RETRY) w_next_step = StepCmd55;
                    else begin w_fail = 1'b1; w_code = 3'd6; end
                end else begin
                    w_fail = 1'b1;
                    w_code = 3'd4;
                end
            end
            StepCmd16: begin
                if (w_r1 == 8'h00) w_finish = 1'b1;
                else begin w_fail = 1'b1; w_code = 3'd5; end
            end
            default: begin
                w_fail = 1'b1;
                w_code = 3'd1;
            end
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            r_state      <= StIdle;
            r_step       <= StepCmd0;
            r_retry      <= 16'd0;
            r_tmo        <= 20'd0;
            r_first_wait <= 1'b0;
            r_done_prev  <= 1'b0;
            r_resp_hi    <= 8'd0;
            r_resp_lo    <= 12'd0;
            r_start      <= 1'b0;
            r_frame      <= FrameIdle;
            r_clk_div    <= 2'b00;
            r_busy       <= 1'b0;
            r_init_done  <= 1'b0;
            r_init_err   <= 1'b0;
            r_err_code   <= 3'd0;
        end else begin
            r_start     <= 1'b0;
            r_done_prev <= spi_done_i;
            case (r_state)
                StIdle, StDone, StError: begin
                    if (init_req_i) begin
                        r_state     <= StIssue;
                        r_step      <= StepCmd0;
                        r_retry     <= 16'd0;
                        r_init_done <= 1'b0;
                        r_init_err  <= 1'b0;
                        r_err_code  <= 3'd0;
                        r_clk_div   <= 2'b00;
                        r_busy      <= 1'b1;
                        r_start     <= 1'b1;
                        r_frame     <= FrameCmd0;
                    end
                end
                StIssue: begin
                    r_tmo        <= 20'd0;
                    r_first_wait <= 1'b1;
                    r_state      <= StWait;
                end
                StWait: begin
                    r_first_wait <= 1'b0;
                    r_tmo        <= w_tmo_inc;
                    // The first WAIT cycle may still see the previous frame's level.
                    if (!r_first_wait && w_done_rise) begin
                        r_resp_hi <= resp_i[39:32];
                        r_resp_lo <= resp_i[11:0];
                        r_state   <= StEval;
                    end else if (w_tmo_inc == TIMEOUT_CYC) begin
                        r_state    <= StError;
                        r_init_err <= 1'b1;
                        r_err_code <= 3'd7;
                        r_clk_div  <= 2'b00;
                        r_busy     <= 1'b0;
                    end
                end
                StEval: begin
                    r_retry <= w_retry_nx;
                    if (w_fail) begin
                        r_state    <= StError;
                        r_init_err <= 1'b1;
                        r_err_code <= w_code;
                        r_clk_div  <= 2'b00;
                        r_busy     <= 1'b0;
                    end else if (w_finish) begin
                        r_state     <= StDone;
                        r_init_done <= 1'b1;
                        r_clk_div   <= 2'b11;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state <= StIssue;
                        r_step  <= w_next_step;
                        r_frame <= frame_of(w_next_step);
                        r_start <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign spi_start_o   = r_start;
    assign cmd_frame_o   = r_frame;
    assign clk_div_o     = r_clk_div;
    assign spi_sendenb_o = 1'b0;
    assign busy_o        = r_busy;
    assign init_done_o   = r_init_done;
    assign init_err_o    = r_init_err;
    assign err_code_o    = r_err_code;

endmodule

// File: tb/tb_sd_spi_init_seq.sv
// tb_sd_spi_init_seq: bench for the SD SPI init sequencer with a behavioural
// frame engine, a queue of expected frames and a table of response scenarios.
`timescale 1ns/1ps
module tb_sd_spi_init_seq;

    localparam logic [15:0] MAX_RETRY   = 16'd4;
    localparam logic [19:0] TIMEOUT_CYC = 20'd100;
    localparam logic [47:0] F_CMD0   = 48'h400000000095;
    localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
    localparam logic [47:0] F_CMD55  = 48'h770000000001;
    localparam logic [47:0] F_ACMD41 = 48'h694000000001;
    localparam logic [47:0] F_CMD16  = 48'h500000020001;
    localparam int LAT = 3;
    localparam int NVEC = 10;

    logic        spi_clk_i  = 1'b0;
    logic        spi_rst_i  = 1'b0;
    logic        init_req_i = 1'b0;
    logic        spi_done_i = 1'b0;
    logic [79:0] resp_i     = '0;
    logic        spi_start_o;
    logic [47:0] cmd_frame_o;
    logic [1:0]  clk_div_o;
    logic        spi_sendenb_o;
    logic        busy_o;
    logic        init_done_o;
    logic        init_err_o;
    logic [2:0]  err_code_o;

    sd_spi_init_seq #(
        .MAX_RETRY  (MAX_RETRY),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .spi_clk_i    (spi_clk_i),
        .spi_rst_i    (spi_rst_i),
        .init_req_i   (init_req_i),
        .spi_done_i   (spi_done_i),
        .resp_i       (resp_i),
        .spi_start_o  (spi_start_o),
        .cmd_frame_o  (cmd_frame_o),
        .clk_div_o    (clk_div_o),
        .spi_sendenb_o(spi_sendenb_o),
        .busy_o       (busy_o),
        .init_done_o  (init_done_o),
        .init_err_o   (init_err_o),
        .err_code_o   (err_code_o)
    );

    always #5 spi_clk_i = ~spi_clk_i;

    typedef struct {
        int          id;
        logic [7:0]  cmd0_r1;
        logic [7:0]  cmd8_r1;
        logic [11:0] cmd8_echo;
        logic [7:0]  cmd55_r1;
        int          acmd41_busy;   // number of 0x01 answers before acmd41_final
        logic [7:0]  acmd41_final;
        logic [7:0]  cmd16_r1;
        bit          poke_req;      // pulse init_req_i mid-sequence
        bit          exp_done;
        bit          exp_err;
        logic [2:0]  exp_code;
        logic [1:0]  exp_div;
        int          exp_starts;
    } vec_t;

    vec_t        vecs[NVEC];
    vec_t        cur;
    logic [47:0] q_exp[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_starts = 0;
    int          acmd41_cnt = 0;
    bit          eng_silent = 1'b0;
    bit          prev_start = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur.id, act, exp);
        end
    endtask

    // Reference model of the command order for one scenario.
    task automatic push_expected(input vec_t v);
        int retry;
        logic [7:0] r1;
        q_exp.push_back(F_CMD0);
        if (v.cmd0_r1 != 8'h01) return;
        q_exp.push_back(F_CMD8);
        if (v.cmd8_r1 != 8'h01 || v.cmd8_echo != 12'h1AA) return;
        retry = 0;
        for (int k = 0; k < 100; k++) begin
            q_exp.push_back(F_CMD55);
            if (v.cmd55_r1 > 8'h01) return;
            q_exp.push_back(F_ACMD41);
            r1 = (retry < v.acmd41_busy) ? 8'h01 : v.acmd41_final;
            if (r1 == 8'h00) begin
                q_exp.push_back(F_CMD16);
                return;
            end
            if (r1 != 8'h01) return;
            retry++;
            if (retry >= int'(MAX_RETRY)) return;
        end
    endtask

    // Frame engine: checks each started frame, answers LAT cycles later.
    initial begin : engine
        int pend;
        logic [79:0] r;
        logic [47:0] e;
        pend = 0;
        forever begin
            @(negedge spi_clk_i);
            if (!spi_rst_i) begin
                pend = 0;
                spi_done_i = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (prev_start) check("start_pulse_width", 64'(spi_start_o), 64'd0);
                prev_start = spi_start_o;
                if (spi_start_o) begin
                    n_starts++;
                    if (q_exp.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_start (vec %0d): got frame %h expected none",
                                 cur.id, cmd_frame_o);
                    end else begin
                        e = q_exp.pop_front();
                        check("frame", 64'(cmd_frame_o), 64'(e));
                    end
                    r = {16'($urandom), $urandom, $urandom};
                    case (cmd_frame_o)
                        F_CMD0:  r[7:0] = cur.cmd0_r1;
                        F_CMD8:  begin r[39:32] = cur.cmd8_r1; r[11:0] = cur.cmd8_echo; end
                        F_CMD55: r[7:0] = cur.cmd55_r1;
                        F_ACMD41: begin
                            r[7:0] = (acmd41_cnt < cur.acmd41_busy) ? 8'h01 : cur.acmd41_final;
                            acmd41_cnt++;
                        end
                        F_CMD16: r[7:0] = cur.cmd16_r1;
                        default: ;
                    endcase
                    spi_done_i = 1'b0;
                    resp_i = r;
                    pend = eng_silent ? 0 : LAT;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) spi_done_i = 1'b1;
                end
            end
        end
    end

    task automatic kick();
        @(negedge spi_clk_i);
        init_req_i = 1'b1;
        @(negedge spi_clk_i);
        init_req_i = 1'b0;
        check("busy_on_req", 64'(busy_o), 64'd1);
        check("flags_cleared", 64'({init_done_o, init_err_o, err_code_o, clk_div_o}), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        cur = v;
        acmd41_cnt = 0;
        n_starts = 0;
        eng_silent = 1'b0;
        push_expected(v);
        kick();
        cyc = 0;
        while (busy_o && cyc < 5000) begin
            @(negedge spi_clk_i);
            cyc++;
            init_req_i = (v.poke_req && cyc == 20);
        end
        init_req_i = 1'b0;
        check("sequence_ends", 64'(busy_o), 64'd0);
        repeat (3) @(negedge spi_clk_i);
        check("frames_left", 64'(q_exp.size()), 64'd0);
        check("start_count", 64'(n_starts), 64'(v.exp_starts));
        check("init_done", 64'(init_done_o), 64'(v.exp_done));
        check("init_err", 64'(init_err_o), 64'(v.exp_err));
        check("err_code", 64'(err_code_o), 64'(v.exp_code));
        check("clk_div", 64'(clk_div_o), 64'(v.exp_div));
        check("sendenb", 64'(spi_sendenb_o), 64'd0);
        q_exp.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cnt;
        bit found;
        //            id c0     c8r1   echo     c55    busy a41f   c16    poke done err code div starts
        vecs[0] = '{0, 8'h01, 8'h01, 12'h1AA, 8'h01, 0,   8'h00, 8'h00, 0, 1, 0, 3'd0, 2'b11, 5};
        vecs[1] = '{1, 8'h01, 8'h01, 12'h1AA, 8'h01, 3,   8'h00, 8'h00, 1, 1, 0, 3'd0, 2'b11, 11};
        vecs[2] = '{2, 8'h01, 8'h01, 12'h1AA, 8'h01, 255, 8'h00, 8'h00, 0, 0, 1, 3'd6, 2'b00, 10};
        vecs[3] = '{3, 8'h01, 8'h01, 12'h0AA, 8'h01, 0,   8'h00, 8'h00, 0, 0, 1, 3'd2, 2'b00, 2};
        vecs[4] = '{4, 8'h01, 8'h05, 12'h1AA, 8'h01, 0,   8'h00, 8'h00, 0, 0, 1, 3'd2, 2'b00, 2};
        vecs[5] = '{5, 8'h05, 8'h01, 12'h1AA, 8'h01, 0,   8'h00, 8'h00, 0, 0, 1, 3'd1, 2'b00, 1};
        vecs[6] = '{6, 8'h01, 8'h01, 12'h1AA, 8'h05, 0,   8'h00, 8'h00, 0, 0, 1, 3'd3, 2'b00, 3};
        vecs[7] = '{7, 8'h01, 8'h01, 12'h1AA, 8'h01, 0,   8'h04, 8'h00, 0, 0, 1, 3'd4, 2'b00, 4};
        vecs[8] = '{8, 8'h01, 8'h01, 12'h1AA, 8'h01, 0,   8'h00, 8'h04, 0, 0, 1, 3'd5, 2'b00, 5};
        vecs[9] = '{9, 8'h01, 8'h01, 12'h1AA, 8'h00, 0,   8'h00, 8'h00, 0, 1, 0, 3'd0, 2'b11, 5};
        cur = vecs[0];

        // Reset values, then no activity without a request.
        repeat (3) @(negedge spi_clk_i);
        check("rst_start", 64'(spi_start_o), 64'd0);
        check("rst_frame", 64'(cmd_frame_o), 64'hFFFF_FFFF_FFFF);
        check("rst_outputs", 64'({clk_div_o, spi_sendenb_o, busy_o, init_done_o, init_err_o,
                                  err_code_o}), 64'd0);
        spi_rst_i = 1'b1;
        n_starts = 0;
        repeat (10) @(negedge spi_clk_i);
        check("no_start_after_reset", 64'(n_starts), 64'd0);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Engine never answers: timeout exactly TIMEOUT_CYC cycles after WAIT entry.
        cur = vecs[0];
        cur.id = 100;
        eng_silent = 1'b1;
        n_starts = 0;
        q_exp.push_back(F_CMD0);
        kick();
        cnt = 0;
        while (!init_err_o && cnt < 300) begin
            @(negedge spi_clk_i);
            cnt++;
        end
        check("timeout_cycles", 64'(cnt - 1), 64'(TIMEOUT_CYC));
        check("timeout_code", 64'(err_code_o), 64'd7);
        check("timeout_busy_div", 64'({busy_o, clk_div_o}), 64'd0);
        check("timeout_starts", 64'(n_starts), 64'd1);
        eng_silent = 1'b0;
        q_exp.delete();

        // Reset while waiting on ACMD41, then a clean restart from CMD0.
        cur = vecs[0];
        cur.id = 101;
        acmd41_cnt = 0;
        n_starts = 0;
        q_exp.push_back(F_CMD0);
        q_exp.push_back(F_CMD8);
        q_exp.push_back(F_CMD55);
        q_exp.push_back(F_ACMD41);
        kick();
        cnt = 0;
        found = 1'b0;
        while (!found && cnt < 500) begin
            @(negedge spi_clk_i);
            cnt++;
            found = spi_start_o && (cmd_frame_o == F_ACMD41);
        end
        check("acmd41_reached", 64'(found), 64'd1);
        @(negedge spi_clk_i);
        #2 spi_rst_i = 1'b0;
        #1;
        check("midrst_start", 64'(spi_start_o), 64'd0);
        check("midrst_frame", 64'(cmd_frame_o), 64'hFFFF_FFFF_FFFF);
        check("midrst_outputs", 64'({clk_div_o, spi_sendenb_o, busy_o, init_done_o, init_err_o,
                                     err_code_o}), 64'd0);
        @(negedge spi_clk_i);
        @(negedge spi_clk_i);
        #1 spi_rst_i = 1'b1;
        check("midrst_frames_left", 64'(q_exp.size()), 64'd0);
        n_starts = 0;
        repeat (8) @(negedge spi_clk_i);
        check("midrst_no_start", 64'(n_starts), 64'd0);
        q_exp.delete();
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
